// File: rtl/wishbone_arbiter_pkg.sv
// wishbone_arbiter_pkg
//   Shared definitions for the Wishbone round-robin arbiter:
//   - eWishboneArbiterState : arbiter FSM encoding (Idle / Busy)
//   - WISHBONE_ARBITER_TIMEOUT_DAT : read data returned on a forced timeout
//   - Flat bit layout of the Wishbone request/response words used on ports:
//       iWishbone_Ctrl (14 bits) = {stb[13], we[12], adr[11:8], dat[7:0]}
//       iWishbone_Peri ( 9 bits) = {ack[8], dat[7:0]}
//     Multi-port buses pack port i at bits [i*W +: W].
package wishbone_arbiter_pkg;

    typedef enum logic {
        eWishboneArbiter_Idle = 1'b0,
        eWishboneArbiter_Busy = 1'b1
    } eWishboneArbiterState;

    localparam logic [7:0] WISHBONE_ARBITER_TIMEOUT_DAT = 8'hFF;

    localparam int WB_CTRL_W  = 14;  // full controller request word
    localparam int WB_PERI_W  = 9;   // full peripheral response word
    localparam int WB_REQ_W   = 13;  // request payload without stb: {we, adr, dat}
    localparam int WB_STB_BIT = 13;
    localparam int WB_ACK_BIT = 8;
    localparam int WB_DAT_W   = 8;

endpackage

// File: rtl/wishbone_rr_pick.sv
// wishbone_rr_pick
//   Combinational round-robin picker. Returns the first set bit of
//   `pending` found when searching upward from `ptr`, wrapping modulo N_CTRL.
// Ports:
//   pending [N_CTRL-1:0]        : request vector
//   ptr     [$clog2(N_CTRL)-1:0]: index with highest priority this decision
//   valid                       : at least one request is pending
//   idx     [$clog2(N_CTRL)-1:0]: chosen index (0 when valid is low)
module wishbone_rr_pick
    import wishbone_arbiter_pkg::*;
#(
    parameter int N_CTRL = 2
) (
    input  logic [N_CTRL-1:0]         pending,
    input  logic [$clog2(N_CTRL)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(N_CTRL)-1:0] idx
);

    localparam int GW = $clog2(N_CTRL);

    logic [GW:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest candidate back towards ptr; the last hit is
        // the one nearest to ptr, which is the round-robin winner.
        for (int k = N_CTRL - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(N_CTRL)) begin
                cand = cand - (GW + 1)'(N_CTRL);
            end
            if (pending[cand[GW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
//   Round-robin arbiter sharing one Wishbone peripheral port between
//   N_CTRL (2..4) controllers. Each controller's stb pulse is captured into
//   a per-port pending slot; slots are granted in rotating order with one
//   transaction outstanding at the peripheral at a time.
//
// Handshake: a controller issues a one-cycle stb carrying we/adr/dat and
//   must not issue another until it has seen its one-cycle ack; an stb to a
//   still-pending slot is dropped. The arbiter issues a one-cycle stb to the
//   peripheral and waits for a one-cycle ack (read data on dat); that ack is
//   returned, registered, to the granted controller only.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wb_ctrl_c  : N_CTRL x 14-bit requests from controllers
//   wb_ctrl_p  : N_CTRL x 9-bit responses to controllers
//   wb_c       : 14-bit request to the shared peripheral
//   wb_p       : 9-bit response from the shared peripheral
//   grant      : index of the controller last granted
//   busy       : transaction outstanding (stb cycle through response ack cycle)
//   state_dbg  : FSM state (0 = Idle, 1 = Busy)
//
// Configuration:
//   WISHBONE_ARBITER_TIMEOUT_EN : when defined, an 8-bit counter forces
//   completion with dat = 8'hFF after TIMEOUT cycles in Busy without ack.
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter int N_CTRL  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CTRL*WB_CTRL_W-1:0]   wb_ctrl_c,
    output logic [N_CTRL*WB_PERI_W-1:0]   wb_ctrl_p,
    output logic [WB_CTRL_W-1:0]          wb_c,
    input  logic [WB_PERI_W-1:0]          wb_p,
    output logic [$clog2(N_CTRL)-1:0]     grant,
    output logic                          busy,
    output logic                          state_dbg
);

    localparam int GW = $clog2(N_CTRL);

    if (N_CTRL < 2 || N_CTRL > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("wishbone_arbiter: N_CTRL must be 2..4 and TIMEOUT 1..255");
    end

    eWishboneArbiterState state;
    logic [GW-1:0]        ptr;
    logic [N_CTRL-1:0]    pending;
    logic [N_CTRL-1:0]    req_stb;
    logic [N_CTRL-1:0]    slot_clr;
    logic [N_CTRL-1:0]    slot_set;
    logic [WB_REQ_W-1:0]  slot_req [N_CTRL];
    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic                 timeout_hit;
    logic                 rsp_fire;
    logic [WB_DAT_W-1:0]  rsp_dat;

    assign state_dbg = (state == eWishboneArbiter_Busy);

`ifdef WISHBONE_ARBITER_TIMEOUT_EN
    logic [7:0] to_cnt;
    assign timeout_hit = (to_cnt == 8'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // A real ack wins over a coincident timeout and delivers its own data.
    assign rsp_fire = (state == eWishboneArbiter_Busy) && (wb_p[WB_ACK_BIT] || timeout_hit);
    assign rsp_dat  = wb_p[WB_ACK_BIT] ? wb_p[WB_DAT_W-1:0] : WISHBONE_ARBITER_TIMEOUT_DAT;

    always_comb begin
        req_stb  = '0;
        slot_clr = '0;
        slot_set = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            req_stb[i]  = wb_ctrl_c[i*WB_CTRL_W + WB_STB_BIT];
            slot_clr[i] = rsp_fire && (int'(grant) == i);
            // A slot being acked this cycle is free again, so an stb from
            // that same controller is accepted rather than dropped.
            slot_set[i] = req_stb[i] && (!pending[i] || slot_clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < N_CTRL; i++) begin
                slot_req[i] <= '0;
            end
        end else begin
            pending <= (pending & ~slot_clr) | slot_set;
            for (int i = 0; i < N_CTRL; i++) begin
                if (slot_set[i]) begin
                    slot_req[i] <= wb_ctrl_c[i*WB_CTRL_W +: WB_REQ_W];
                end
            end
        end
    end

    // Decision uses registered pending only, so an stb arriving in the same
    // cycle as a grant waits for the next Idle cycle.
    wishbone_rr_pick #(
        .N_CTRL (N_CTRL)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= eWishboneArbiter_Idle;
            ptr       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            wb_c      <= '0;
            wb_ctrl_p <= '0;
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            // stb and ack are single-cycle pulses; payload fields hold.
            wb_c[WB_STB_BIT] <= 1'b0;
            for (int i = 0; i < N_CTRL; i++) begin
                wb_ctrl_p[i*WB_PERI_W + WB_ACK_BIT] <= 1'b0;
            end

            case (state)
                eWishboneArbiter_Idle: begin
                    if (pick_valid) begin
                        wb_c  <= {1'b1, slot_req[pick_idx]};
                        grant <= pick_idx;
                        busy  <= 1'b1;
                        state <= eWishboneArbiter_Busy;
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end

                eWishboneArbiter_Busy: begin
                    if (rsp_fire) begin
                        for (int i = 0; i < N_CTRL; i++) begin
                            if (int'(grant) == i) begin
                                wb_ctrl_p[i*WB_PERI_W +: WB_PERI_W] <= {1'b1, rsp_dat};
                            end
                        end
                        ptr   <= (grant == GW'(N_CTRL - 1)) ? '0 : grant + GW'(1);
                        state <= eWishboneArbiter_Idle;
                        // busy stays high through the response ack cycle.
                    end
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end

                default: state <= eWishboneArbiter_Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
`timescale 1ns/1ps
module tb_wishbone_arbiter;
    import wishbone_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*14-1:0]   wb_ctrl_c;
    logic [N*9-1:0]    wb_ctrl_p;
    logic [13:0]       wb_c;
    logic [8:0]        wb_p;
    logic [1:0]        grant;
    logic              busy;
    logic              state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wishbone_arbiter #(
        .N_CTRL  (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_ctrl_c (wb_ctrl_c),
        .wb_ctrl_p (wb_ctrl_p),
        .wb_c      (wb_c),
        .wb_p      (wb_p),
        .grant     (grant),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stb(input int p, input logic we, input logic [3:0] adr, input logic [7:0] dat);
        wb_ctrl_c[p*14 +: 14] = {1'b1, we, adr, dat};
    endtask

    task automatic clear_stb();
        wb_ctrl_c = '0;
    endtask

    task automatic drive_ack(input logic [7:0] dat);
        wb_p = {1'b1, dat};
    endtask

    task automatic clear_ack();
        wb_p = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_stb();
        clear_ack();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] acks();
        logic [N-1:0] a;
        for (int p = 0; p < N; p++) a[p] = wb_ctrl_p[p*9 + 8];
        return a;
    endfunction

    function automatic logic [7:0] port_dat(input int p);
        return wb_ctrl_p[p*9 +: 8];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_stb(0, 1'b1, 4'hA, 8'h55);
        drive_ack(8'h77);
        tick();
        tick();
        n_checks++;
        if ({wb_c, wb_ctrl_p, grant, busy, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wb_c=%h p=%h grant=%0d busy=%b st=%b, expected all zero", wb_c, wb_ctrl_p, grant, busy, state_dbg);
        end
        rst = 1'b0;
        clear_stb();
        clear_ack();
        tick();
        tick();
        n_checks++;
        if ({wb_c[13], busy, state_dbg} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_no_stale_req: got stb=%b busy=%b st=%b, expected 0 0 0", wb_c[13], busy, state_dbg);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        drive_stb(0, 1'b0, 4'h3, 8'h00);
        tick();
        clear_stb();
        n_checks++;
        if ({wb_c[13], busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_read_e0: got stb=%b busy=%b, expected 0 0", wb_c[13], busy);
        end
        tick();
        n_checks++;
        if ({wb_c, grant, busy} !== {14'h2300, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_read_grant: got wb_c=%h grant=%0d busy=%b, expected 2300 0 1", wb_c, grant, busy);
        end
        tick();
        n_checks++;
        if (wb_c !== 14'h0300) begin
            n_fail++;
            $display("FAIL single_read_stb_pulse: got wb_c=%h, expected 0300", wb_c);
        end
        tick();
        drive_ack(8'hA5);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), port_dat(0), busy} !== {3'b001, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL single_read_ack: got acks=%b dat=%h busy=%b, expected 001 a5 1", acks(), port_dat(0), busy);
        end
        tick();
        n_checks++;
        if ({acks(), port_dat(0), busy, state_dbg} !== {3'b000, 8'hA5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_read_after: got acks=%b dat=%h busy=%b st=%b, expected 000 a5 0 0", acks(), port_dat(0), busy, state_dbg);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_stb(0, 1'b1, 4'h1, 8'h11);
        drive_stb(1, 1'b1, 4'h2, 8'h22);
        tick();
        clear_stb();
        tick();
        n_checks++;
        if ({wb_c, grant} !== {14'h3111, 2'd0}) begin
            n_fail++;
            $display("FAIL simul_first: got wb_c=%h grant=%0d, expected 3111 0", wb_c, grant);
        end
        drive_ack(8'h00);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), wb_c[13]} !== {3'b001, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_ack0: got acks=%b stb=%b, expected 001 0", acks(), wb_c[13]);
        end
        tick();
        n_checks++;
        if ({wb_c, grant, busy, acks()} !== {14'h3222, 2'd1, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL simul_second: got wb_c=%h grant=%0d busy=%b acks=%b, expected 3222 1 1 000", wb_c, grant, busy, acks());
        end
        drive_ack(8'h00);
        tick();
        clear_ack();
        n_checks++;
        if (acks() !== 3'b010) begin
            n_fail++;
            $display("FAIL simul_ack1: got acks=%b, expected 010", acks());
        end
        tick();
        n_checks++;
        if ({acks(), busy, wb_c[13]} !== 5'b00000) begin
            n_fail++;
            $display("FAIL simul_done: got acks=%b busy=%b stb=%b, expected 000 0 0", acks(), busy, wb_c[13]);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_port;
        do_reset();
        for (int p = 0; p < N; p++) drive_stb(p, 1'b0, 4'(p + 4), 8'(p * 16));
        tick();
        clear_stb();
        for (int t = 0; t < 9; t++) begin
            exp_port = 2'(t % 3);
            for (int k = 0; k < 10 && wb_c[13] !== 1'b1; k++) tick();
            n_checks++;
            if (wb_c[13] !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_wait_stb: no peripheral stb for transaction %0d within 10 cycles", t);
                break;
            end
            n_checks++;
            if ({grant, wb_c[11:8]} !== {exp_port, 4'(exp_port) + 4'd4}) begin
                n_fail++;
                $display("FAIL fair_grant: txn %0d got grant=%0d adr=%h, expected %0d %h", t, grant, wb_c[11:8], exp_port, 4'(exp_port) + 4'd4);
            end
            drive_ack(8'(t));
            tick();
            clear_ack();
            n_checks++;
            if ({acks(), port_dat(int'(exp_port))} !== {3'b001 << exp_port, 8'(t)}) begin
                n_fail++;
                $display("FAIL fair_ack: txn %0d got acks=%b dat=%h, expected %b %h", t, acks(), port_dat(int'(exp_port)), 3'b001 << exp_port, 8'(t));
            end
            if (t < 6) drive_stb(int'(exp_port), 1'b0, 4'(exp_port) + 4'd4, 8'(int'(exp_port) * 16));
            tick();
            clear_stb();
        end
        tick();
        tick();
        n_checks++;
        if ({busy, state_dbg, wb_c[13]} !== 3'b000) begin
            n_fail++;
            $display("FAIL fair_drained: got busy=%b st=%b stb=%b, expected 0 0 0", busy, state_dbg, wb_c[13]);
        end
    endtask

    task automatic test_violation();
        do_reset();
        drive_stb(0, 1'b0, 4'h5, 8'h00);
        tick();
        drive_stb(0, 1'b0, 4'hF, 8'h00);
        tick();
        clear_stb();
        n_checks++;
        if ({wb_c, grant} !== {14'h2500, 2'd0}) begin
            n_fail++;
            $display("FAIL viol_grant: got wb_c=%h grant=%0d, expected 2500 0", wb_c, grant);
        end
        drive_ack(8'h3C);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), port_dat(0)} !== {3'b001, 8'h3C}) begin
            n_fail++;
            $display("FAIL viol_ack: got acks=%b dat=%h, expected 001 3c", acks(), port_dat(0));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({wb_c[13], wb_c[11:8]} !== {1'b0, 4'h5}) begin
                n_fail++;
                $display("FAIL viol_dropped: cycle %0d got stb=%b adr=%h, expected 0 5", k, wb_c[13], wb_c[11:8]);
            end
        end
        drive_ack(8'h5A);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), port_dat(0), busy, state_dbg} !== {3'b000, 8'h3C, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got acks=%b dat=%h busy=%b st=%b, expected 000 3c 0 0", acks(), port_dat(0), busy, state_dbg);
        end
        tick();
        n_checks++;
        if ({acks(), state_dbg, wb_c[13]} !== 5'b00000) begin
            n_fail++;
            $display("FAIL idle_ack_after: got acks=%b st=%b stb=%b, expected 000 0 0", acks(), state_dbg, wb_c[13]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_stb(1, 1'b1, 4'h7, 8'h77);
        tick();
        clear_stb();
        tick();
        n_checks++;
        if ({wb_c, grant, busy} !== {14'h3777, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got wb_c=%h grant=%0d busy=%b, expected 3777 1 1", wb_c, grant, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({wb_c, wb_ctrl_p, grant, busy, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_zero: got wb_c=%h p=%h grant=%0d busy=%b st=%b, expected all zero", wb_c, wb_ctrl_p, grant, busy, state_dbg);
        end
        tick();
        tick();
        drive_ack(8'h99);
        tick();
        clear_ack();
        n_checks++;
        if ({wb_c, wb_ctrl_p, grant, busy, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_late_ack: got wb_c=%h p=%h grant=%0d busy=%b st=%b, expected all zero", wb_c, wb_ctrl_p, grant, busy, state_dbg);
        end
        tick();
        n_checks++;
        if ({acks(), busy, wb_c[13]} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid_after: got acks=%b busy=%b stb=%b, expected 000 0 0", acks(), busy, wb_c[13]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_stb(2, 1'b0, 4'h1, 8'h00);
        tick();
        clear_stb();
        tick();
        n_checks++;
        if ({wb_c, grant} !== {14'h2100, 2'd2}) begin
            n_fail++;
            $display("FAIL b2b_first: got wb_c=%h grant=%0d, expected 2100 2", wb_c, grant);
        end
        drive_ack(8'h42);
        drive_stb(2, 1'b0, 4'h9, 8'h00);
        tick();
        clear_ack();
        clear_stb();
        n_checks++;
        if ({acks(), port_dat(2)} !== {3'b100, 8'h42}) begin
            n_fail++;
            $display("FAIL b2b_ack1: got acks=%b dat=%h, expected 100 42", acks(), port_dat(2));
        end
        tick();
        n_checks++;
        if ({wb_c, grant, busy} !== {14'h2900, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_regrant: got wb_c=%h grant=%0d busy=%b, expected 2900 2 1", wb_c, grant, busy);
        end
        drive_ack(8'h43);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), port_dat(2)} !== {3'b100, 8'h43}) begin
            n_fail++;
            $display("FAIL b2b_ack2: got acks=%b dat=%h, expected 100 43", acks(), port_dat(2));
        end
        tick();
        n_checks++;
        if ({busy, state_dbg} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_done: got busy=%b st=%b, expected 0 0", busy, state_dbg);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_stb(0, 1'b0, 4'h6, 8'h00);
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
        drive_stb(1, 1'b0, 4'h7, 8'h00);
`endif
        tick();
        clear_stb();
        tick();
        n_checks++;
        if ({wb_c, grant} !== {14'h2600, 2'd0}) begin
            n_fail++;
            $display("FAIL timeout_grant: got wb_c=%h grant=%0d, expected 2600 0", wb_c, grant);
        end
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            tick();
            n_checks++;
            if (acks() !== 3'b000) begin
                n_fail++;
                $display("FAIL timeout_early: cycle %0d after stb got acks=%b, expected 000", k, acks());
            end
        end
        tick();
        n_checks++;
        if ({acks(), port_dat(0)} !== {3'b001, 8'hFF}) begin
            n_fail++;
            $display("FAIL timeout_ack: got acks=%b dat=%h, expected 001 ff", acks(), port_dat(0));
        end
        tick();
        n_checks++;
        if ({wb_c, grant} !== {14'h2700, 2'd1}) begin
            n_fail++;
            $display("FAIL timeout_next: got wb_c=%h grant=%0d, expected 2700 1", wb_c, grant);
        end
        drive_ack(8'h12);
        tick();
        clear_ack();
        n_checks++;
        if ({acks(), port_dat(1)} !== {3'b010, 8'h12}) begin
            n_fail++;
            $display("FAIL timeout_real_ack: got acks=%b dat=%h, expected 010 12", acks(), port_dat(1));
        end
`else
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if ({acks(), busy, state_dbg} !== {3'b000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL no_timeout_wait: got acks=%b busy=%b st=%b, expected 000 1 1", acks(), busy, state_dbg);
        end
`endif
        do_reset();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        wb_ctrl_c = '0;
        wb_p      = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_violation();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, got no end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
